// File: rtl/mem_access_ctrl_pkg.sv
// mem_pkg: shared widths, depth and FSM encoding for the RAM initiator.
package mem_pkg;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator for the 512x32 registered-read RAM.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              Read,
    output logic              Write,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Mdatain,
    input  logic [DATA_W-1:0] data_output
);
    state_t     state;
    logic [1:0] cnt;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_out <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            Read      <= 1'b0;
            Write     <= 1'b0;
            Address   <= '0;
            Mdatain   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // conflict and range faults share one err pulse and never touch the RAM
                    if (req_read && req_write)
                        err <= 1'b1;
                    else if ((req_read || req_write) && addr_in[31:ADDR_W] != '0)
                        err <= 1'b1;
                    else if (req_read) begin
                        state   <= RD_REQ;
                        busy    <= 1'b1;
                        Read    <= 1'b1;
                        Address <= addr_in[ADDR_W-1:0];
                    end else if (req_write) begin
                        state   <= WR_REQ;
                        busy    <= 1'b1;
                        Write   <= 1'b1;
                        Address <= addr_in[ADDR_W-1:0];
                        Mdatain <= wdata_in;
                    end
                end
                RD_REQ: begin
                    Read  <= 1'b0;
                    cnt   <= 2'(READ_LATENCY - 1);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt != 2'd0)
                        cnt <= cnt - 2'd1;
                    else begin
                        rdata_out <= data_output;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_REQ: begin
                    Write <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the initiator against behavioural 512x32 RAMs (latency 1 and 3).
module tb_mem_access_ctrl;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        pre = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [31:0] addr_in = '0, wdata_in = '0;
    logic [31:0] rdata_out, Mdatain, data_output;
    logic        done, busy, err, Read, Write;
    logic [8:0]  Address;

    logic        req_read3 = 1'b0, req_write3 = 1'b0;
    logic [31:0] addr3 = '0, wdata3 = '0;
    logic [31:0] rdata3, Mdatain3, data_output3;
    logic        done3, busy3, err3, Read3, Write3;
    logic [8:0]  Address3;

    logic [31:0] mem0 [512];
    logic [31:0] mem3 [512];
    logic [31:0] p1, p2;

    int total = 0;
    int bad = 0;

    always #5 Clock = ~Clock;

    mem_access_ctrl #(.READ_LATENCY(1)) u0 (
        .Clock(Clock), .Reset(Reset), .req_read(req_read), .req_write(req_write),
        .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out), .done(done),
        .busy(busy), .err(err), .Read(Read), .Write(Write), .Address(Address),
        .Mdatain(Mdatain), .data_output(data_output)
    );

    mem_access_ctrl #(.READ_LATENCY(3)) u3 (
        .Clock(Clock), .Reset(Reset), .req_read(req_read3), .req_write(req_write3),
        .addr_in(addr3), .wdata_in(wdata3), .rdata_out(rdata3), .done(done3),
        .busy(busy3), .err(err3), .Read(Read3), .Write(Write3), .Address(Address3),
        .Mdatain(Mdatain3), .data_output(data_output3)
    );

    always @(posedge Clock) begin
        if (pre) mem0[9'h054] <= 32'h0000_0097;
        else if (Write) mem0[Address] <= Mdatain;
        if (Read) data_output <= mem0[Address];
    end

    always @(posedge Clock) begin
        if (pre) mem3[9'h054] <= 32'h0000_0097;
        else if (Write3) mem3[Address3] <= Mdatain3;
        if (Read3) p1 <= mem3[Address3];
        p2 <= p1;
        data_output3 <= p2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        tick(); tick();
        chk("rst_rdata", rdata_out, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_read", Read, 0);
        chk("rst_write", Write, 0);
        chk("rst_addr", Address, 0);
        chk("rst_mdatain", Mdatain, 0);
        Reset = 1'b0; pre = 1'b0;
        tick();

        req_read = 1'b1; addr_in = 32'h54;
        tick();
        req_read = 1'b0;
        chk("ld_read_e", Read, 1);
        chk("ld_addr_e", Address, 9'h054);
        chk("ld_busy_e", busy, 1);
        chk("ld_done_e", done, 0);
        tick();
        chk("ld_read_e1", Read, 0);
        chk("ld_busy_e1", busy, 1);
        chk("ld_done_e1", done, 0);
        tick();
        chk("ld_done_e2", done, 1);
        chk("ld_rdata_e2", rdata_out, 32'h97);
        chk("ld_busy_e2", busy, 0);
        tick();
        chk("ld_done_e3", done, 0);
        chk("ld_rdata_e3", rdata_out, 32'h97);

        req_write = 1'b1; addr_in = 32'h34; wdata_in = 32'hDEAD_BEEF;
        tick();
        req_write = 1'b0;
        chk("st_write_e", Write, 1);
        chk("st_read_e", Read, 0);
        chk("st_addr_e", Address, 9'h034);
        chk("st_mdatain_e", Mdatain, 32'hDEAD_BEEF);
        chk("st_busy_e", busy, 1);
        tick();
        chk("st_write_e1", Write, 0);
        chk("st_done_e1", done, 1);
        chk("st_busy_e1", busy, 0);
        req_read = 1'b1; addr_in = 32'h34;
        tick();
        req_read = 1'b0;
        chk("b2b_read", Read, 1);
        chk("b2b_done_low", done, 0);
        chk("b2b_addr", Address, 9'h034);
        tick(); tick();
        chk("b2b_done", done, 1);
        chk("b2b_rdata", rdata_out, 32'hDEAD_BEEF);

        req_read = 1'b1; addr_in = 32'h200;
        tick();
        req_read = 1'b0;
        chk("oor_err", err, 1);
        chk("oor_read", Read, 0);
        chk("oor_busy", busy, 0);
        tick();
        chk("oor_err_clr", err, 0);
        chk("oor_rdata", rdata_out, 32'hDEAD_BEEF);
        chk("oor_read2", Read, 0);

        req_read = 1'b1; req_write = 1'b1; addr_in = 32'h10;
        tick();
        req_read = 1'b0; req_write = 1'b0;
        chk("cf_err", err, 1);
        chk("cf_read", Read, 0);
        chk("cf_write", Write, 0);
        chk("cf_busy", busy, 0);
        tick();
        chk("cf_err_clr", err, 0);

        req_read = 1'b1; addr_in = 32'h54;
        tick();
        req_read = 1'b0;
        req_write = 1'b1; wdata_in = 32'h1111_1111;
        tick();
        chk("ign_write_e1", Write, 0);
        chk("ign_err_e1", err, 0);
        tick();
        req_write = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_rdata", rdata_out, 32'h97);
        chk("ign_write_e2", Write, 0);
        tick();
        chk("ign_mem", mem0[9'h054], 32'h97);

        req_read = 1'b1; addr_in = 32'h54;
        tick();
        req_read = 1'b0;
        tick();
        #2 Reset = 1'b1;
        #1;
        chk("mr_read", Read, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rdata", rdata_out, 0);
        chk("mr_done", done, 0);
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_done", done, 0);
        end
        req_read = 1'b1; addr_in = 32'h54;
        tick();
        req_read = 1'b0;
        chk("mr_ld_read", Read, 1);
        tick(); tick();
        chk("mr_ld_done", done, 1);
        chk("mr_ld_rdata", rdata_out, 32'h97);

        req_read3 = 1'b1; addr3 = 32'h54;
        tick();
        req_read3 = 1'b0;
        chk("l3_read_e", Read3, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("l3_done_early", done3, 0);
            chk("l3_busy_early", busy3, 1);
            chk("l3_rdata_early", rdata3, 0);
        end
        tick();
        chk("l3_done", done3, 1);
        chk("l3_rdata", rdata3, 32'h97);
        chk("l3_busy", busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
